// File: rtl/mul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// mul_pipe_ctrl
//
// Control and result stage wrapped around an external combinational signed
// 32x32 multiplier. Requests arrive over a valid/ready handshake, are held in
// the operand stage (S1) that drives the multiplier, and the corrected 32-bit
// result is captured in the result stage (S2), which presents it together with
// the request tag over a second valid/ready handshake.
//
// The multiplier always computes a signed x signed product. The unsigned and
// mixed-sign forms are recovered here by adding the operand-sign correction
// terms to the upper half of that product.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous kill of every in-flight operation
//   req_valid   request present
//   req_ready   a request can be accepted this cycle
//   req_op      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//   req_rs1     operand A
//   req_rs2     operand B
//   req_tag     opaque tag, returned unchanged with the result
//   mul_in1     multiplier operand A (S1 register)
//   mul_in2     multiplier operand B (S1 register)
//   mul_out     signed 64-bit product of mul_in1 * mul_in2
//   resp_valid  result present
//   resp_ready  consumer accepts the result
//   resp_data   32-bit result
//   resp_tag    tag belonging to resp_data
// -----------------------------------------------------------------------------
module mul_pipe_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_in1,
    output logic [31:0]      mul_in2,
    input  logic [63:0]      mul_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } op_e;

    // ---------------------------------------------------------------------
    // Stage registers
    // ---------------------------------------------------------------------
    logic             s1_valid_reg;
    op_e              s1_op_reg;
    logic [31:0]      s1_a_reg;
    logic [31:0]      s1_b_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_valid_reg;
    logic [31:0]      s2_data_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic             s1_valid_next;
    logic             s2_valid_next;
    logic [31:0]      result_next;

    // ---------------------------------------------------------------------
    // Handshake / advance conditions
    // ---------------------------------------------------------------------
    logic s2_free;
    logic s1_adv;
    logic accept;

    assign s2_free = !s2_valid_reg || resp_ready;
    assign s1_adv  = s1_valid_reg && s2_free;

    // S1 can take a new request when it is empty or is emptying this cycle.
    // Depends only on flush, resp_ready and state; never on req_valid.
    assign req_ready = !flush && (!s1_valid_reg || s1_adv);
    assign accept    = req_valid && req_ready;

    // ---------------------------------------------------------------------
    // Sign correction of the signed product.
    //
    // Treating an operand with bit 31 set as unsigned adds 2^32 to its value,
    // which adds (other operand << 32) to the product. Only the upper half is
    // affected, so MUL never needs a correction.
    // ---------------------------------------------------------------------
    logic [63:0] corr_from_b;   // applied when B is treated as unsigned
    logic [63:0] corr_from_a;   // applied when A is treated as unsigned
    logic [63:0] product_adj;

    assign corr_from_b = s1_b_reg[31] ? {s1_a_reg, 32'd0} : 64'd0;
    assign corr_from_a = s1_a_reg[31] ? {s1_b_reg, 32'd0} : 64'd0;

    always_comb begin
        product_adj = mul_out;
        result_next = 32'd0;
        case (s1_op_reg)
            OP_MULHSU: product_adj = mul_out + corr_from_b;
            OP_MULHU:  product_adj = mul_out + corr_from_b + corr_from_a;
            default:   product_adj = mul_out;
        endcase
        if (s1_op_reg == OP_MUL) begin
            result_next = product_adj[31:0];
        end else begin
            result_next = product_adj[63:32];
        end
    end

    // ---------------------------------------------------------------------
    // Valid-bit next state. Flush wins over everything; a response that is
    // handshaken in the flush cycle has already been delivered.
    // ---------------------------------------------------------------------
    always_comb begin
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        if (flush) begin
            s1_valid_next = 1'b0;
            s2_valid_next = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_next = 1'b1;
            end else if (s1_adv) begin
                s1_valid_next = 1'b0;
            end

            if (s1_adv) begin
                s2_valid_next = 1'b1;
            end else if (resp_ready) begin
                s2_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
        end
    end

    // ---------------------------------------------------------------------
    // S1 operand register: loads only on accept, so the multiplier inputs
    // stay stable while the stage is stalled.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op_reg  <= OP_MUL;
            s1_a_reg   <= 32'd0;
            s1_b_reg   <= 32'd0;
            s1_tag_reg <= '0;
        end else if (accept) begin
            s1_op_reg  <= op_e'(req_op);
            s1_a_reg   <= req_rs1;
            s1_b_reg   <= req_rs2;
            s1_tag_reg <= req_tag;
        end
    end

    // ---------------------------------------------------------------------
    // S2 result register: loads on advance and otherwise holds, which keeps
    // resp_data/resp_tag stable while the consumer stalls.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data_reg <= 32'd0;
            s2_tag_reg  <= '0;
        end else if (s1_adv) begin
            s2_data_reg <= result_next;
            s2_tag_reg  <= s1_tag_reg;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign mul_in1    = s1_a_reg;
    assign mul_in2    = s1_b_reg;
    assign resp_valid = s2_valid_reg;
    assign resp_data  = s2_data_reg;
    assign resp_tag   = s2_tag_reg;

endmodule

// File: doc/mul_pipe_ctrl.md
Name: mul_pipe_ctrl

Overview:
Pipeline control and result stage for the M-extension multiply path. Accepts multiply requests over a valid/ready handshake and registers the operands that drive the combinational signed 32x32 multiplier (Multiplier32). Captures the 64-bit signed product, applies the unsigned/mixed-sign correction, selects the result half, and returns the 32-bit result with its tag over a second valid/ready handshake.

Parameters:
TAG_W, 5, width of the request/response tag (destination register index)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight operations
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_op  input  2  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
req_rs1  input  32  operand A
req_rs2  input  32  operand B
req_tag  input  TAG_W  opaque tag, returned unchanged
mul_in1  output  32  to multiplier in1 (S1 operand A)
mul_in2  output  32  to multiplier in2 (S1 operand B)
mul_out  input  64  from multiplier: signed product of mul_in1*mul_in2
resp_valid  output  1  result present
resp_ready  input  1  consumer accepts result
resp_data  output  32  result
resp_tag  output  TAG_W  tag of the result

Behaviour:
- Two stages: S1 (operand register, drives the multiplier) and S2 (result register). Each holds a valid bit, op, tag and data.
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, resp_valid=0, req_ready=1 once rst_n is high, and mul_in1, mul_in2, resp_data and resp_tag all 0. S1 and S2 data registers reset to 0.
- Accept: a request is taken when req_valid && req_ready at the clock edge. It loads S1 with rs1, rs2, op and tag.
- s2_free = !s2_valid || resp_ready.
- s1_adv = s1_valid && s2_free.
- req_ready = !flush && (!s1_valid || s1_adv). Its only combinational dependencies are flush, resp_ready and state.
- Latency: a request accepted at edge N gives resp_valid=1 after edge N+1 (visible in cycle N+1), provided S2 was free. Sustained throughput is 1 per cycle while resp_ready=1.
- S2 capture on s1_adv. Let P = mul_out and A/B = the S1 operands. Corrections are applied mod 2^64:
  - MUL: R = P[31:0].
  - MULH: R = P[63:32].
  - MULHSU: P' = P + ((B[31] ? A : 0) << 32). R = P'[63:32].
  - MULHU: P' = P + ((A[31] ? B : 0) << 32) + ((B[31] ? A : 0) << 32). R = P'[63:32].
- S2 valid update: s2_valid becomes 1 on s1_adv. It becomes 0 when resp_ready && !s1_adv. It holds otherwise.
- Output hold: resp_data and resp_tag are S2 registers, stable while resp_valid && !resp_ready.
- S1 valid update: s1_valid becomes 1 on accept. It becomes 0 when s1_adv occurs with no accept. It holds while stalled, and mul_in1/mul_in2 hold with it.
- Full condition: with s1_valid=1, s2_valid=1 and resp_ready=0, req_ready=0 and no state changes.
- Simultaneous consume and accept: a consume, an advance and an accept in the same cycle all take effect; no bubble is inserted.
- Flush (sync, highest priority): on the edge where flush=1, s1_valid and s2_valid clear to 0 and no request is accepted (req_ready=0 while flush=1). A response handshaken in the same cycle is still considered delivered. Data registers are don't-care afterwards.
- Reset mid-operation: all valid bits clear immediately (async). Nothing is delivered after reset.
- Ordering: responses leave strictly in acceptance order. No reordering and no drops except by flush or reset.
- The multiplier is purely combinational between S1 and S2. No multicycle path is allowed.

Test Plan:
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF tag=3 -> resp_data=0xFFFFFFFE, resp_tag=3, one cycle after accept. Same operands: MUL -> 0x00000001, MULH -> 0x00000000.
- MULHSU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULH rs1=0x80000000 rs2=0x80000000 -> 0x40000000. MULHU rs1=0x80000000 rs2=0x00000002 -> 0x00000001.
- Back-to-back stream of 8 MULs (rs1=i, rs2=i+1, tags 0..7) with resp_ready=1 -> req_ready stays 1, 8 consecutive responses i*(i+1) with tags in order.
- Backpressure: resp_ready=0 while offering 3 requests -> only 2 accepted and req_ready=0 on the third. resp_data is unchanged during the stall. Raising resp_ready delivers all 3 in order, with the third accepted on the first consume cycle.
- Flush with both stages full and a request pending -> no response appears, req_ready=0 in the flush cycle. The next request (MUL 6*7) returns 42 with latency 1.
- Assert rst_n=0 asynchronously mid-clock with both stages valid -> resp_valid drops immediately, and resp_data=0. After release, the first accepted request completes normally.
